// File: rtl/can_pkg.sv
// Shared CAN MAC definitions: CRC-15 geometry, polynomial and register types.
package can_pkg;

  localparam int          CAN_CRC_W    = 15;
  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;
  localparam logic [14:0] CAN_CRC_INIT = 15'h0000;
  localparam int          CAN_CNT_W    = 8;

  typedef logic [CAN_CRC_W-1:0] can_crc_t;

  typedef enum logic [1:0] {
    MODE_CLEAR,
    MODE_SHIFT,
    MODE_ACCUM
  } crc_mode_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial step of a Galois-form CRC LFSR: feeds bit_in into crc_in.
module crc_lfsr_step #(
  parameter int               WIDTH = 15,
  parameter logic [WIDTH-1:0] POLY  = 15'h4599
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc_out
);

  logic feedback;

  // The implicit x^WIDTH term is the bit shifted out; it decides whether POLY is folded back in.
  assign feedback = bit_in ^ crc_in[WIDTH-1];
  assign crc_out  = {crc_in[WIDTH-2:0], 1'b0} ^ (feedback ? POLY : '0);

endmodule

// File: rtl/crc_unit.sv
// Serial CAN CRC-15 generator/checker: accumulates unstuffed bits, shifts the CRC out for TX,
// and flags a zero residue for RX.
module crc_unit
  import can_pkg::*;
#(
  parameter int               WIDTH = CAN_CRC_W,
  parameter logic [WIDTH-1:0] POLY  = CAN_CRC_POLY,
  parameter logic [WIDTH-1:0] INIT  = CAN_CRC_INIT,
  parameter int               CNT_W = CAN_CNT_W
) (
  input  logic             bitstrb,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             bitval,
  input  logic             shift_out,
  output logic [WIDTH-1:0] crc,
  output logic             txbit,
  output logic             crc_zero,
  output logic [CNT_W-1:0] bitcnt
);

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_step;
  logic [CNT_W-1:0] cnt_q;
  crc_mode_e        mode;

  crc_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .bit_in  (bitval),
    .crc_out (crc_step)
  );

  // NOTE: assign a default before any branch so every path drives mode and no latch is inferred.
  always_comb begin
    mode = MODE_ACCUM;
    if (clear)          mode = MODE_CLEAR;
    else if (shift_out) mode = MODE_SHIFT;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge bitstrb or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= INIT;
      cnt_q <= '0;
    end else begin
      case (mode)
        MODE_CLEAR: begin
          crc_q <= INIT;
          cnt_q <= '0;
        end
        MODE_SHIFT: begin
          crc_q <= {crc_q[WIDTH-2:0], 1'b0};
        end
        default: begin
          crc_q <= crc_step;
          // Saturate rather than wrap so oversize frames never look short.
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
      endcase
    end
  end

  assign crc      = crc_q;
  assign txbit    = crc_q[WIDTH-1];
  assign crc_zero = (crc_q == '0);
  assign bitcnt   = cnt_q;

endmodule

// File: tb/tb_crc_unit.sv
// Scoreboard bench for crc_unit: stimulus queues expectations, monitors compare after each edge/probe.
module tb_crc_unit;

  logic        bitstrb;
  logic        rst_n;
  logic        clear;
  logic        bitval;
  logic        shift_out;
  logic [14:0] crc;
  logic        txbit;
  logic        crc_zero;
  logic [7:0]  bitcnt;

  crc_unit dut (
    .bitstrb   (bitstrb),
    .rst_n     (rst_n),
    .clear     (clear),
    .bitval    (bitval),
    .shift_out (shift_out),
    .crc       (crc),
    .txbit     (txbit),
    .crc_zero  (crc_zero),
    .bitcnt    (bitcnt)
  );

  initial bitstrb = 1'b0;
  always #5 bitstrb = ~bitstrb;

  // mask: bit0 crc, bit1 bitcnt, bit2 crc_zero, bit3 txbit
  typedef struct {
    bit          on_edge;
    logic [3:0]  mask;
    logic [14:0] crc;
    logic [7:0]  cnt;
    logic        zero;
    logic        tx;
    string       name;
  } exp_t;

  exp_t q[$];
  event probe_ev;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t mk(string n, logic [3:0] m, logic [14:0] c = '0,
                              logic [7:0] k = '0, logic z = 1'b0, logic t = 1'b0);
    exp_t e;
    e.on_edge = 1'b1;
    e.mask    = m;
    e.crc     = c;
    e.cnt     = k;
    e.zero    = z;
    e.tx      = t;
    e.name    = n;
    return e;
  endfunction

  // Reference: long division of msg * x^15 by the full generator 0xC599 (zero initial value).
  function automatic logic [14:0] ref_crc(input logic [127:0] msg, input int n);
    logic [142:0] v;
    v = 143'(msg) << 15;
    for (int i = n + 14; i >= 15; i--) begin
      if (v[i]) v[i -: 16] = v[i -: 16] ^ 16'hC599;
    end
    return v[14:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic evaluate(input exp_t e);
    if (e.mask[0]) check({e.name, ".crc"},      16'(crc),      16'(e.crc));
    if (e.mask[1]) check({e.name, ".bitcnt"},   16'(bitcnt),   16'(e.cnt));
    if (e.mask[2]) check({e.name, ".crc_zero"}, 16'(crc_zero), 16'(e.zero));
    if (e.mask[3]) check({e.name, ".txbit"},    16'(txbit),    16'(e.tx));
  endtask

  always @(posedge bitstrb) begin
    #1;
    if (q.size() > 0 && q[0].on_edge) evaluate(q.pop_front());
  end

  always @(probe_ev) begin
    #1;
    if (q.size() > 0 && !q[0].on_edge) evaluate(q.pop_front());
  end

  task automatic step(input logic c, input logic s, input logic v, input exp_t e);
    clear     = c;
    shift_out = s;
    bitval    = v;
    e.on_edge = 1'b1;
    q.push_back(e);
    @(negedge bitstrb);
  endtask

  task automatic probe(input exp_t e);
    e.on_edge = 1'b0;
    q.push_back(e);
    ->probe_ev;
    #2;
  endtask

  task automatic feed(input logic [127:0] msg, input int n, input exp_t last);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, msg[n-1-i], (i == n - 1) ? last : mk("nop", 4'h0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [50:0]  frame;
  logic [14:0]  fcrc;
  logic [65:0]  rx;
  exp_t         e;

  initial begin
    frame     = {1'b0, 11'h123, 1'b0, 6'b000100, 32'hDEADBEEF};
    fcrc      = ref_crc(128'(frame), 51);
    rst_n     = 1'b0;
    clear     = 1'b0;
    bitval    = 1'b0;
    shift_out = 1'b0;
    repeat (2) @(negedge bitstrb);

    // Reset state, no edges since release
    rst_n = 1'b1;
    probe(mk("reset", 4'hF, 15'h0000, 8'd0, 1'b1, 1'b0));
    @(negedge bitstrb);

    // Single bits from cleared state
    step(1'b1, 1'b0, 1'b0, mk("nop", 4'h0));
    step(1'b0, 1'b0, 1'b1, mk("bit1", 4'hF, 15'h4599, 8'd1, 1'b0, 1'b1));
    step(1'b0, 1'b0, 1'b0, mk("bit0", 4'hB, 15'h4EAB, 8'd2, 1'b0, 1'b1));

    // 51 zeros keep CRC at zero
    step(1'b1, 1'b0, 1'b1, mk("nop", 4'h0));
    feed(128'd0, 51, mk("zeros", 4'h7, 15'h0000, 8'd51, 1'b1));

    // Full frame, then shift the CRC out MSB first (bitval toggled to show it is ignored)
    step(1'b1, 1'b0, 1'b0, mk("nop", 4'h0));
    feed(128'(frame), 51, mk("frame", 4'hB, fcrc, 8'd51, 1'b0, fcrc[14]));
    for (int k = 0; k < 15; k++) begin
      if (k < 14) e = mk($sformatf("tx%0d", k), 4'hA, 15'h0, 8'd51, 1'b0, fcrc[13-k]);
      else        e = mk("tx_done", 4'h7, 15'h0000, 8'd51, 1'b1);
      step(1'b0, 1'b1, k[0], e);
    end

    // RX residue: frame plus its CRC leaves zero; single-bit errors do not
    rx = {frame, fcrc};
    step(1'b1, 1'b0, 1'b0, mk("nop", 4'h0));
    feed(128'(rx), 66, mk("rx_ok", 4'h7, 15'h0000, 8'd66, 1'b1));
    step(1'b1, 1'b0, 1'b0, mk("nop", 4'h0));
    feed(128'(rx ^ (66'd1 << 35)), 66, mk("rx_data_err", 4'h6, 15'h0, 8'd66, 1'b0));
    step(1'b1, 1'b0, 1'b0, mk("nop", 4'h0));
    feed(128'(rx ^ 66'd8), 66, mk("rx_crc_err", 4'h4, 15'h0, 8'd0, 1'b0));

    // Async reset mid-frame
    step(1'b1, 1'b0, 1'b0, mk("nop", 4'h0));
    feed(128'(frame[50:41]), 10, mk("partial", 4'h3, ref_crc(128'(frame[50:41]), 10), 8'd10));
    rst_n = 1'b0;
    probe(mk("mid_reset", 4'hF, 15'h0000, 8'd0, 1'b1, 1'b0));
    @(negedge bitstrb);
    rst_n = 1'b1;

    // Clear beats shift
    feed(128'(frame[50:46]), 5, mk("pre_clr", 4'h3, ref_crc(128'(frame[50:46]), 5), 8'd5));
    step(1'b1, 1'b1, 1'b1, mk("clr_wins", 4'h7, 15'h0000, 8'd0, 1'b1));

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      if      (i == 253) e = mk("cnt_254",  4'h2, 15'h0, 8'd254);
      else if (i == 254) e = mk("cnt_255",  4'h2, 15'h0, 8'd255);
      else if (i == 255) e = mk("cnt_hold", 4'h2, 15'h0, 8'd255);
      else if (i == 299) e = mk("cnt_300",  4'h2, 15'h0, 8'd255);
      else               e = mk("nop", 4'h0);
      step(1'b0, 1'b0, i[0], e);
    end

    repeat (2) @(negedge bitstrb);
    check("queue_drained", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
